pool_apply_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single pool-apply request port (id+len) among NUM_REQ WQE sources.

---
 rtl/pool_apply_arbiter_if.sv | 38 +++
 rtl/pool_apply_arbiter.sv | 157 +++++++++++++++
 tb/tb_pool_apply_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_apply_arbiter_if.sv
// Handshake bundle between the WQE parsers, the pool-apply arbiter and pool_apply.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface pool_apply_arbiter_if #(
  parameter int unsigned NUM_REQ           = 4,
  parameter int unsigned REQ_ID_WIDTH      = 2,
  parameter int unsigned WQE_INDEX_WIDTH   = 10,
  parameter int unsigned WQE_SOURCE_LENGTH = 11
);
  localparam int unsigned ID_LEN_W = WQE_INDEX_WIDTH + WQE_SOURCE_LENGTH;

  logic [NUM_REQ-1:0]          s_axis_req_valid;
  logic [NUM_REQ*ID_LEN_W-1:0] s_axis_req_id_len;
  logic [NUM_REQ-1:0]          s_axis_req_ready;

  logic                        m_axis_Papply_valid;
  logic [ID_LEN_W-1:0]         m_axis_Papply_id_len;
  logic [REQ_ID_WIDTH-1:0]     m_axis_Papply_req_id;
  logic                        m_axis_Papply_ready;

  logic                        s_cpl_valid;
  logic [REQ_ID_WIDTH-1:0]     s_cpl_req_id;

  modport slave (
    input  s_axis_req_valid, s_axis_req_id_len,
    output s_axis_req_ready,
    output m_axis_Papply_valid, m_axis_Papply_id_len, m_axis_Papply_req_id,
    input  m_axis_Papply_ready,
    input  s_cpl_valid, s_cpl_req_id
  );

  modport master (
    output s_axis_req_valid, s_axis_req_id_len,
    input  s_axis_req_ready,
    input  m_axis_Papply_valid, m_axis_Papply_id_len, m_axis_Papply_req_id,
    output m_axis_Papply_ready,
    output s_cpl_valid, s_cpl_req_id
  );
endinterface

// File: rtl/pool_apply_arbiter.sv
// Round-robin arbiter sharing the pool-apply request port among NUM_REQ WQE sources,
// with per-requester outstanding-credit limits and zero-length request dropping.
module pool_apply_arbiter #(
  parameter int unsigned NUM_REQ           = 4,
  parameter int unsigned REQ_ID_WIDTH      = 2,
  parameter int unsigned WQE_INDEX_WIDTH   = 10,
  parameter int unsigned WQE_SOURCE_LENGTH = 11,
  parameter int unsigned MAX_OUTSTANDING   = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  pool_apply_arbiter_if.slave   bus,
  output logic                  o_zero_len_drop,
  output logic                  o_cpl_underflow
);
  localparam int unsigned IW    = WQE_INDEX_WIDTH;
  localparam int unsigned LW    = WQE_SOURCE_LENGTH;
  localparam int unsigned W     = IW + LW;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]              state_q, state_d;
  logic                    valid_q, valid_d;
  logic [W-1:0]            id_len_q, id_len_d;
  logic [REQ_ID_WIDTH-1:0] req_id_q, req_id_d;
  logic [REQ_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                    drop_q, drop_d;
  logic                    uf_q, uf_d;
  logic [CNT_W-1:0]        cnt_q [NUM_REQ];
  logic [CNT_W-1:0]        cnt_d [NUM_REQ];

  logic [W-1:0]            slot [NUM_REQ];
  logic [NUM_REQ-1:0]      eligible;
  logic [NUM_REQ-1:0]      ready_c;
  logic [NUM_REQ-1:0]      inc;
  logic [NUM_REQ-1:0]      dec;
  logic                    found_hi, found_lo, grant_found, cpl_hit;
  logic [REQ_ID_WIDTH-1:0] g_hi, g_lo, grant_idx;
  logic [W-1:0]            grant_data;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      slot[i]     = bus.s_axis_req_id_len[i*W +: W];
      eligible[i] = bus.s_axis_req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  // Rotating priority: first eligible above rr_ptr wins, else first at or below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    g_hi     = '0;
    g_lo     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (eligible[i]) begin
        if (REQ_ID_WIDTH'(i) > rr_ptr_q) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            g_hi     = REQ_ID_WIDTH'(i);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          g_lo     = REQ_ID_WIDTH'(i);
        end
      end
    end
    grant_found = found_hi || found_lo;
    grant_idx   = found_hi ? g_hi : g_lo;
    grant_data  = slot[grant_idx];
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    id_len_d = id_len_q;
    req_id_d = req_id_q;
    rr_ptr_d = rr_ptr_q;
    drop_d   = 1'b0;
    uf_d     = 1'b0;
    ready_c  = '0;
    inc      = '0;
    dec      = '0;
    cpl_hit  = 1'b0;
    cnt_d    = cnt_q;

    if (state_q == ST_IDLE) begin
      if (grant_found) begin
        ready_c[grant_idx] = 1'b1;
        rr_ptr_d           = grant_idx;
        if (grant_data[W-1 -: LW] != '0) begin
          id_len_d       = grant_data;
          req_id_d       = grant_idx;
          valid_d        = 1'b1;
          inc[grant_idx] = 1'b1;
          state_d        = ST_HOLD;
        end else begin
          drop_d = 1'b1;
        end
      end
    end else if (valid_q && bus.m_axis_Papply_ready) begin
      valid_d = 1'b0;
      state_d = ST_IDLE;
    end

    // Completions to an empty counter or an unknown requester are flagged, never wrapped.
    if (bus.s_cpl_valid) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (bus.s_cpl_req_id == REQ_ID_WIDTH'(i) && cnt_q[i] != '0) begin
          dec[i]  = 1'b1;
          cpl_hit = 1'b1;
        end
      end
      uf_d = !cpl_hit;
    end

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (inc[i] && !dec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec[i] && !inc[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      id_len_q <= '0;
      req_id_q <= '0;
      rr_ptr_q <= REQ_ID_WIDTH'(NUM_REQ - 1);
      drop_q   <= 1'b0;
      uf_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      id_len_q <= id_len_d;
      req_id_q <= req_id_d;
      rr_ptr_q <= rr_ptr_d;
      drop_q   <= drop_d;
      uf_q     <= uf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.s_axis_req_ready     = ready_c;
  assign bus.m_axis_Papply_valid  = valid_q;
  assign bus.m_axis_Papply_id_len = id_len_q;
  assign bus.m_axis_Papply_req_id = req_id_q;
  assign o_zero_len_drop          = drop_q;
  assign o_cpl_underflow          = uf_q;
endmodule

// File: tb/tb_pool_apply_arbiter.sv
// Directed bench for pool_apply_arbiter: round-robin order, back-pressure, credit limit,
// zero-length drop, completion underflow and reset while holding a request.
module tb_pool_apply_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned RW = 2;
  localparam int unsigned IW = 10;
  localparam int unsigned LW = 11;
  localparam int unsigned MO = 8;
  localparam int unsigned W  = IW + LW;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic o_zero_len_drop;
  logic o_cpl_underflow;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pool_apply_arbiter_if #(.NUM_REQ(NR), .REQ_ID_WIDTH(RW), .WQE_INDEX_WIDTH(IW),
                          .WQE_SOURCE_LENGTH(LW)) bus ();

  pool_apply_arbiter #(.NUM_REQ(NR), .REQ_ID_WIDTH(RW), .WQE_INDEX_WIDTH(IW),
                       .WQE_SOURCE_LENGTH(LW), .MAX_OUTSTANDING(MO)) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .bus             (bus),
    .o_zero_len_drop (o_zero_len_drop),
    .o_cpl_underflow (o_cpl_underflow)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic v, input logic [LW-1:0] len,
                         input logic [IW-1:0] id);
    bus.s_axis_req_valid[i]         = v;
    bus.s_axis_req_id_len[i*W +: W] = {len, id};
  endtask

  task automatic cpl_pulse(input logic [RW-1:0] id);
    bus.s_cpl_valid  = 1'b1;
    bus.s_cpl_req_id = id;
    tick();
    bus.s_cpl_valid  = 1'b0;
  endtask

  task automatic test_reset();
    bus.s_axis_req_valid    = '0;
    bus.s_axis_req_id_len   = '0;
    bus.m_axis_Papply_ready = 1'b0;
    bus.s_cpl_valid         = 1'b0;
    bus.s_cpl_req_id        = '0;
    sys_rst_n               = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus.m_axis_Papply_valid, bus.m_axis_Papply_id_len, bus.m_axis_Papply_req_id} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%0b idlen=%0h rid=%0d want all 0",
               bus.m_axis_Papply_valid, bus.m_axis_Papply_id_len, bus.m_axis_Papply_req_id);
    end
    n_cmp++;
    if ({o_zero_len_drop, o_cpl_underflow, bus.s_axis_req_ready} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_pulses: got drop=%0b uf=%0b ready=%b want 0",
               o_zero_len_drop, o_cpl_underflow, bus.s_axis_req_ready);
    end
    for (int i = 0; i < NR; i++) begin
      n_cmp++;
      if (dut.cnt_q[i] !== 4'd0) begin
        n_err++;
        $display("FAIL reset_cnt%0d: got %0d want 0", i, dut.cnt_q[i]);
      end
    end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 11'd5, 10'(i));
    bus.m_axis_Papply_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_rdy = 4'(1 << (k % 4));
      @(negedge sys_clk);
      n_cmp++;
      if (bus.s_axis_req_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL rr_ready[%0d]: got %b want %b", k, bus.s_axis_req_ready, exp_rdy);
      end
      tick();
      n_cmp++;
      if ({bus.m_axis_Papply_valid, bus.m_axis_Papply_req_id, bus.m_axis_Papply_id_len}
          !== {1'b1, 2'(k % 4), 11'd5, 10'(k % 4)}) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: got v=%0b rid=%0d idlen=%0h want v=1 rid=%0d idlen=%0h", k,
                 bus.m_axis_Papply_valid, bus.m_axis_Papply_req_id, bus.m_axis_Papply_id_len,
                 k % 4, {11'd5, 10'(k % 4)});
      end
      @(negedge sys_clk);
      n_cmp++;
      if (bus.s_axis_req_ready !== 4'b0) begin
        n_err++;
        $display("FAIL rr_hold_ready[%0d]: got %b want 0000", k, bus.s_axis_req_ready);
      end
      tick();
      n_cmp++;
      if (bus.m_axis_Papply_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rr_release[%0d]: got v=%0b want 0", k, bus.m_axis_Papply_valid);
      end
    end
    bus.s_axis_req_valid = '0;
    n_cmp++;
    if ({dut.cnt_q[0], dut.cnt_q[1], dut.cnt_q[2], dut.cnt_q[3]} !== {4'd2, 4'd1, 4'd1, 4'd1}) begin
      n_err++;
      $display("FAIL rr_counts: got %0d %0d %0d %0d want 2 1 1 1",
               dut.cnt_q[0], dut.cnt_q[1], dut.cnt_q[2], dut.cnt_q[3]);
    end
    cpl_pulse(2'd0); cpl_pulse(2'd0); cpl_pulse(2'd1); cpl_pulse(2'd2); cpl_pulse(2'd3);
    n_cmp++;
    if ({dut.cnt_q[0], dut.cnt_q[1], dut.cnt_q[2], dut.cnt_q[3], o_cpl_underflow} !== 17'd0) begin
      n_err++;
      $display("FAIL rr_cpl_drain: got %0d %0d %0d %0d uf=%0b want 0 0 0 0 uf=0",
               dut.cnt_q[0], dut.cnt_q[1], dut.cnt_q[2], dut.cnt_q[3], o_cpl_underflow);
    end
  endtask

  task automatic test_stall();
    bus.m_axis_Papply_ready = 1'b0;
    set_req(1, 1'b1, 11'd3, 10'd7);
    @(negedge sys_clk);
    n_cmp++;
    if (bus.s_axis_req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL stall_ready: got %b want 0010", bus.s_axis_req_ready);
    end
    tick();
    // Scramble the source data and raise every valid: held output must not move.
    set_req(1, 1'b1, 11'd6, 10'd1);
    set_req(0, 1'b1, 11'd2, 10'd2);
    set_req(3, 1'b1, 11'd2, 10'd3);
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      n_cmp++;
      if ({bus.m_axis_Papply_valid, bus.m_axis_Papply_req_id, bus.m_axis_Papply_id_len,
           bus.s_axis_req_ready} !== {1'b1, 2'd1, 11'd3, 10'd7, 4'b0}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v=%0b rid=%0d idlen=%0h ready=%b want v=1 rid=1 idlen=%0h ready=0000",
                 k, bus.m_axis_Papply_valid, bus.m_axis_Papply_req_id, bus.m_axis_Papply_id_len,
                 bus.s_axis_req_ready, {11'd3, 10'd7});
      end
      tick();
    end
    bus.s_axis_req_valid    = '0;
    bus.m_axis_Papply_ready = 1'b1;
    tick();
    n_cmp++;
    if ({bus.m_axis_Papply_valid, dut.cnt_q[1]} !== {1'b0, 4'd1}) begin
      n_err++;
      $display("FAIL stall_release: got v=%0b cnt1=%0d want v=0 cnt1=1",
               bus.m_axis_Papply_valid, dut.cnt_q[1]);
    end
    cpl_pulse(2'd1);
  endtask

  task automatic test_credit_limit();
    bus.m_axis_Papply_ready = 1'b1;
    set_req(2, 1'b1, 11'd4, 10'd2);
    for (int k = 0; k < 8; k++) begin
      @(negedge sys_clk);
      n_cmp++;
      if (bus.s_axis_req_ready !== 4'b0100) begin
        n_err++;
        $display("FAIL credit_ready[%0d]: got %b want 0100", k, bus.s_axis_req_ready);
      end
      tick();
      n_cmp++;
      if ({bus.m_axis_Papply_valid, bus.m_axis_Papply_req_id} !== {1'b1, 2'd2}) begin
        n_err++;
        $display("FAIL credit_fwd[%0d]: got v=%0b rid=%0d want v=1 rid=2", k,
                 bus.m_axis_Papply_valid, bus.m_axis_Papply_req_id);
      end
      tick();
    end
    n_cmp++;
    if (dut.cnt_q[2] !== 4'd8) begin
      n_err++;
      $display("FAIL credit_cnt_max: got %0d want 8", dut.cnt_q[2]);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      n_cmp++;
      if ({bus.s_axis_req_ready, bus.m_axis_Papply_valid} !== 5'b0) begin
        n_err++;
        $display("FAIL credit_withheld[%0d]: got ready=%b v=%0b want 0000 v=0", k,
                 bus.s_axis_req_ready, bus.m_axis_Papply_valid);
      end
      tick();
    end
    set_req(3, 1'b1, 11'd1, 10'd3);
    @(negedge sys_clk);
    n_cmp++;
    if (bus.s_axis_req_ready !== 4'b1000) begin
      n_err++;
      $display("FAIL credit_skip_ready: got %b want 1000", bus.s_axis_req_ready);
    end
    tick();
    set_req(3, 1'b0, 11'd1, 10'd3);
    n_cmp++;
    if ({bus.m_axis_Papply_valid, bus.m_axis_Papply_req_id} !== {1'b1, 2'd3}) begin
      n_err++;
      $display("FAIL credit_skip_fwd: got v=%0b rid=%0d want v=1 rid=3",
               bus.m_axis_Papply_valid, bus.m_axis_Papply_req_id);
    end
    tick();
    cpl_pulse(2'd2);
    @(negedge sys_clk);
    n_cmp++;
    if (bus.s_axis_req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL credit_regain: got %b want 0100", bus.s_axis_req_ready);
    end
    tick();
    set_req(2, 1'b0, 11'd4, 10'd2);
    n_cmp++;
    if ({bus.m_axis_Papply_valid, bus.m_axis_Papply_req_id, dut.cnt_q[2]} !== {1'b1, 2'd2, 4'd8}) begin
      n_err++;
      $display("FAIL credit_ninth: got v=%0b rid=%0d cnt2=%0d want v=1 rid=2 cnt2=8",
               bus.m_axis_Papply_valid, bus.m_axis_Papply_req_id, dut.cnt_q[2]);
    end
    tick();
    cpl_pulse(2'd3);
    for (int k = 0; k < 8; k++) begin
      cpl_pulse(2'd2);
      n_cmp++;
      if ({o_cpl_underflow, dut.cnt_q[2]} !== {1'b0, 4'(7 - k)}) begin
        n_err++;
        $display("FAIL credit_drain[%0d]: got uf=%0b cnt2=%0d want uf=0 cnt2=%0d", k,
                 o_cpl_underflow, dut.cnt_q[2], 7 - k);
      end
    end
  endtask

  task automatic test_zero_len();
    set_req(0, 1'b1, 11'd0, 10'd9);
    @(negedge sys_clk);
    n_cmp++;
    if (bus.s_axis_req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL zlen_ready: got %b want 0001", bus.s_axis_req_ready);
    end
    tick();
    set_req(0, 1'b0, 11'd0, 10'd9);
    n_cmp++;
    if ({o_zero_len_drop, bus.m_axis_Papply_valid, dut.cnt_q[0]} !== {1'b1, 1'b0, 4'd0}) begin
      n_err++;
      $display("FAIL zlen_drop: got drop=%0b v=%0b cnt0=%0d want drop=1 v=0 cnt0=0",
               o_zero_len_drop, bus.m_axis_Papply_valid, dut.cnt_q[0]);
    end
    tick();
    n_cmp++;
    if ({o_zero_len_drop, bus.m_axis_Papply_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL zlen_pulse_end: got drop=%0b v=%0b want 0 0",
               o_zero_len_drop, bus.m_axis_Papply_valid);
    end
  endtask

  task automatic test_cpl_underflow();
    cpl_pulse(2'd3);
    n_cmp++;
    if ({o_cpl_underflow, dut.cnt_q[3]} !== {1'b1, 4'd0}) begin
      n_err++;
      $display("FAIL uf_pulse: got uf=%0b cnt3=%0d want uf=1 cnt3=0", o_cpl_underflow, dut.cnt_q[3]);
    end
    tick();
    n_cmp++;
    if (o_cpl_underflow !== 1'b0) begin
      n_err++;
      $display("FAIL uf_pulse_end: got %0b want 0", o_cpl_underflow);
    end
    bus.m_axis_Papply_ready = 1'b1;
    set_req(1, 1'b1, 11'd4, 10'd1);
    tick();
    set_req(1, 1'b0, 11'd4, 10'd1);
    tick();
    set_req(1, 1'b1, 11'd4, 10'd1);
    bus.s_cpl_valid  = 1'b1;
    bus.s_cpl_req_id = 2'd1;
    @(negedge sys_clk);
    n_cmp++;
    if ({bus.s_axis_req_ready, dut.cnt_q[1]} !== {4'b0010, 4'd1}) begin
      n_err++;
      $display("FAIL same_cycle_pre: got ready=%b cnt1=%0d want 0010 cnt1=1",
               bus.s_axis_req_ready, dut.cnt_q[1]);
    end
    tick();
    bus.s_cpl_valid = 1'b0;
    set_req(1, 1'b0, 11'd4, 10'd1);
    n_cmp++;
    if ({dut.cnt_q[1], o_cpl_underflow, bus.m_axis_Papply_valid} !== {4'd1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL same_cycle_cnt: got cnt1=%0d uf=%0b v=%0b want cnt1=1 uf=0 v=1",
               dut.cnt_q[1], o_cpl_underflow, bus.m_axis_Papply_valid);
    end
    tick();
    cpl_pulse(2'd1);
  endtask

  task automatic test_reset_in_hold();
    bus.m_axis_Papply_ready = 1'b1;
    set_req(0, 1'b1, 11'd2, 10'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) begin
        bus.m_axis_Papply_ready = 1'b0;
        set_req(0, 1'b0, 11'd2, 10'd0);
      end else begin
        tick();
      end
    end
    tick();
    n_cmp++;
    if ({bus.m_axis_Papply_valid, dut.cnt_q[0]} !== {1'b1, 4'd4}) begin
      n_err++;
      $display("FAIL hold_pre_reset: got v=%0b cnt0=%0d want v=1 cnt0=4",
               bus.m_axis_Papply_valid, dut.cnt_q[0]);
    end
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    n_cmp++;
    if ({bus.m_axis_Papply_valid, bus.m_axis_Papply_id_len, dut.cnt_q[0], dut.cnt_q[1],
         dut.cnt_q[2], dut.cnt_q[3]} !== '0) begin
      n_err++;
      $display("FAIL hold_reset: got v=%0b idlen=%0h cnt=%0d %0d %0d %0d want all 0",
               bus.m_axis_Papply_valid, bus.m_axis_Papply_id_len, dut.cnt_q[0], dut.cnt_q[1],
               dut.cnt_q[2], dut.cnt_q[3]);
    end
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 11'd1, 10'(i));
    bus.m_axis_Papply_ready = 1'b1;
    @(negedge sys_clk);
    n_cmp++;
    if (bus.s_axis_req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL hold_restart_ready: got %b want 0001", bus.s_axis_req_ready);
    end
    tick();
    bus.s_axis_req_valid = '0;
    n_cmp++;
    if ({bus.m_axis_Papply_valid, bus.m_axis_Papply_req_id} !== {1'b1, 2'd0}) begin
      n_err++;
      $display("FAIL hold_restart_grant: got v=%0b rid=%0d want v=1 rid=0",
               bus.m_axis_Papply_valid, bus.m_axis_Papply_req_id);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_credit_limit();
    test_zero_len();
    test_cpl_underflow();
    test_reset_in_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
